// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the single byte-wide RAM/IO port.
// Instruction fetch (IF) and the load/store buffer (LS) share the port; LS has
// priority. Every access is split into per-byte RAM cycles; read data is
// assembled little-endian and handed back with a one-cycle done pulse.
// The RAM pins are decoded from registered state only (plus io_buffer_full for
// the UART stall), so they change exactly at clock edges.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [2:0]  len_r, len_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] buf_r, buf_s;
    logic        if_done_r, if_done_s;
    logic        ls_done_r, ls_done_s;
    logic [31:0] if_data_r, if_data_s;
    logic [31:0] ls_rdata_r, ls_rdata_s;

    logic        io_stall_s;
    logic [31:0] byte_addr_s;
    logic [1:0]  rd_idx_s;
    logic [31:0] rd_merge_s;

    // Byte count for an LS access: 00 -> 1, 01 -> 2, 10/11 -> 4.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Select byte idx of a word (little-endian).
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Insert byte b into lane idx of word w.
    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [7:0] b,
                                               input logic [1:0] idx);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Shared helpers: current byte address, UART stall, and read-data merge.
    // The byte on mem_din belongs to the address issued one cycle earlier (cnt-1).
    always_comb begin
        byte_addr_s = addr_r + {29'd0, cnt_r};
        io_stall_s  = (state_r == LS_WR) && (addr_r[17:16] == 2'b11) && io_buffer_full;
        rd_idx_s    = cnt_r[1:0] - 2'd1;
        rd_merge_s  = merge_byte(buf_r, mem_din, rd_idx_s);
    end

    // RAM pin decode; zeros whenever no byte cycle is being issued.
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        case (state_r)
            IF_RD, LS_RD: begin
                if (cnt_r < len_r) begin
                    mem_a = byte_addr_s;
                end else begin
                    mem_a = 32'd0;
                end
            end
            LS_WR: begin
                if (io_stall_s) begin
                    mem_a = 32'd0;
                end else begin
                    mem_a    = byte_addr_s;
                    mem_dout = byte_sel(wdata_r, cnt_r[1:0]);
                    mem_wr   = 1'b1;
                end
            end
            default: begin
                mem_a = 32'd0;
            end
        endcase
    end

    // Next-state logic: arbitration, byte sequencing, completion and flush.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        len_s      = len_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        buf_s      = buf_r;
        if_done_s  = 1'b0;
        ls_done_s  = 1'b0;
        if_data_s  = if_data_r;
        ls_rdata_s = ls_rdata_r;
        case (state_r)
            IDLE: begin
                // No grant while a done pulse is out: requester drops req meanwhile.
                if (!if_done_r && !ls_done_r) begin
                    if (ls_req) begin
                        state_s = ls_we ? LS_WR : LS_RD;
                        addr_s  = ls_addr;
                        len_s   = len_to_bytes(ls_len);
                        wdata_s = ls_wdata;
                        cnt_s   = 3'd0;
                        buf_s   = 32'd0;
                    end else if (if_req && !flush) begin
                        state_s = IF_RD;
                        addr_s  = if_addr;
                        len_s   = 3'd4;
                        cnt_s   = 3'd0;
                        buf_s   = 32'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            IF_RD, LS_RD: begin
                if ((state_r == IF_RD) && flush) begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                end else begin
                    if (cnt_r != 3'd0) begin
                        buf_s = rd_merge_s;
                    end else begin
                        buf_s = buf_r;
                    end
                    if (cnt_r == len_r) begin
                        state_s = IDLE;
                        cnt_s   = 3'd0;
                        if (state_r == IF_RD) begin
                            if_done_s = 1'b1;
                            if_data_s = rd_merge_s;
                        end else begin
                            ls_done_s  = 1'b1;
                            ls_rdata_s = rd_merge_s;
                        end
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
            end
            LS_WR: begin
                if (io_stall_s) begin
                    cnt_s = cnt_r;
                end else if (cnt_r == (len_r - 3'd1)) begin
                    state_s   = IDLE;
                    cnt_s     = 3'd0;
                    ls_done_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State and output registers; rdy low freezes everything, done pulses included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            len_r      <= 3'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            buf_r      <= 32'd0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
            if_data_r  <= 32'd0;
            ls_rdata_r <= 32'd0;
        end else if (rdy) begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            len_r      <= len_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            buf_r      <= buf_s;
            if_done_r  <= if_done_s;
            ls_done_r  <= ls_done_s;
            if_data_r  <= if_data_s;
            ls_rdata_r <= ls_rdata_s;
        end
    end

    assign if_done  = if_done_r;
    assign ls_done  = ls_done_r;
    assign if_data  = if_data_r;
    assign ls_rdata = ls_rdata_r;

endmodule
